// File: rtl/sub_txn_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sub_txn_ctrl
// Brief    : AXI4 subordinate transaction controller. Captures AW/W/AR
//            transfers from the RX endpoints, arbitrates writes against reads
//            round-robin, drives the local memory port and launches B/R
//            responses through the TX endpoints.
// Revision : 1.0 - initial release
// ============================================================================
module sub_txn_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         aw_new,
  input  logic [ADDR_W-1:0]            aw_addr,
  output logic                         aw_hold,
  input  logic                         w_new,
  input  logic [DATA_W-1:0]            w_data,
  output logic                         w_hold,
  input  logic                         ar_new,
  input  logic [ADDR_W-1:0]            ar_addr,
  output logic                         ar_hold,
  output logic                         b_en,
  output logic [1:0]                   b_resp,
  input  logic                         b_done,
  output logic                         r_en,
  output logic [DATA_W-1:0]            r_data,
  output logic [1:0]                   r_resp,
  input  logic                         r_done,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [$clog2(MEM_BYTES)-1:0] mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         proto_err
);

  localparam int                c_NB         = DATA_W / 8;
  localparam int                c_AW         = $clog2(MEM_BYTES);
  localparam logic [1:0]        c_OKAY       = 2'b00;
  localparam logic [1:0]        c_SLVERR     = 2'b10;
  localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~ADDR_W'(c_NB - 1);
  localparam logic [ADDR_W:0]   c_NB_EXT     = (ADDR_W+1)'(c_NB);
  localparam logic [ADDR_W:0]   c_LIMIT      = (ADDR_W+1)'(MEM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_MEM  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_MEM  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RD_RESP = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_aw_pend;
  logic [ADDR_W-1:0] r_aw_q;
  logic              r_w_pend;
  logic [DATA_W-1:0] r_w_q;
  logic              r_ar_pend;
  logic [ADDR_W-1:0] r_ar_q;
  logic              r_proto_err;
  logic              r_last_rd;
  logic              r_rd_ok;
  logic [1:0]        r_b_resp;
  logic [1:0]        r_r_resp;
  logic [DATA_W-1:0] r_r_data;

  logic              w_wr_elig;
  logic              w_rd_elig;
  logic              w_grant_wr;
  logic              w_grant_rd;
  logic              w_wr_ok;
  logic              w_rd_ok;

  // The end of the aligned word is computed one bit wider so high addresses cannot wrap into range.
  function automatic logic f_in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr & c_ALIGN_MASK} + c_NB_EXT) <= c_LIMIT;
  endfunction

  assign w_wr_ok    = f_in_range(r_aw_q);
  assign w_rd_ok    = f_in_range(r_ar_q);
  assign w_wr_elig  = r_aw_pend & r_w_pend;
  assign w_rd_elig  = r_ar_pend;
  // On contention the side that did not win last time goes first.
  assign w_grant_wr = (r_state == S_IDLE) & w_wr_elig & (~w_rd_elig | r_last_rd);
  assign w_grant_rd = (r_state == S_IDLE) & w_rd_elig & (~w_wr_elig | ~r_last_rd);

  assign aw_hold   = r_aw_pend;
  assign w_hold    = r_w_pend;
  assign ar_hold   = r_ar_pend;
  assign proto_err = r_proto_err;
  assign b_resp    = r_b_resp;
  assign r_resp    = r_r_resp;
  assign r_data    = r_r_data;

  // State register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode plus memory strobes and TX enables.
  always_comb begin
    w_next    = r_state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    b_en      = 1'b0;
    r_en      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_wr)      w_next = S_WR_MEM;
        else if (w_grant_rd) w_next = S_RD_MEM;
      end
      S_WR_MEM: begin
        if (w_wr_ok) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = c_AW'(r_aw_q & c_ALIGN_MASK);
          mem_wdata = r_w_q;
        end
        w_next = S_WR_RESP;
      end
      S_WR_RESP: begin
        b_en = 1'b1;
        if (b_done) w_next = S_IDLE;
      end
      S_RD_MEM: begin
        if (w_rd_ok) begin
          mem_en   = 1'b1;
          mem_addr = c_AW'(r_ar_q & c_ALIGN_MASK);
        end
        w_next = S_RD_WAIT;
      end
      S_RD_WAIT: w_next = S_RD_RESP;
      S_RD_RESP: begin
        r_en = 1'b1;
        if (r_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Capture RX transfers; a pulse on a channel that is still pending is dropped and flagged.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_aw_pend   <= 1'b0;
      r_aw_q      <= '0;
      r_w_pend    <= 1'b0;
      r_w_q       <= '0;
      r_ar_pend   <= 1'b0;
      r_ar_q      <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (aw_new && !r_aw_pend) begin
        r_aw_pend <= 1'b1;
        r_aw_q    <= aw_addr;
      end else if (r_state == S_WR_MEM) begin
        r_aw_pend <= 1'b0;
      end
      if (w_new && !r_w_pend) begin
        r_w_pend <= 1'b1;
        r_w_q    <= w_data;
      end else if (r_state == S_WR_MEM) begin
        r_w_pend <= 1'b0;
      end
      if (ar_new && !r_ar_pend) begin
        r_ar_pend <= 1'b1;
        r_ar_q    <= ar_addr;
      end else if (r_state == S_RD_MEM) begin
        r_ar_pend <= 1'b0;
      end
      if ((aw_new && r_aw_pend) || (w_new && r_w_pend) || (ar_new && r_ar_pend))
        r_proto_err <= 1'b1;
    end
  end

  // Arbitration history and response registers; the read range result is kept
  // because ar_q may be reloaded by a new AR while the read is in flight.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_last_rd <= 1'b1;
      r_rd_ok   <= 1'b0;
      r_b_resp  <= c_OKAY;
      r_r_resp  <= c_OKAY;
      r_r_data  <= '0;
    end else begin
      if (w_grant_wr || w_grant_rd) r_last_rd <= w_grant_rd;
      if (r_state == S_WR_MEM) r_b_resp <= w_wr_ok ? c_OKAY : c_SLVERR;
      if (r_state == S_RD_MEM) r_rd_ok <= w_rd_ok;
      if (r_state == S_RD_WAIT) begin
        r_r_data <= r_rd_ok ? mem_rdata : '0;
        r_r_resp <= r_rd_ok ? c_OKAY : c_SLVERR;
      end
    end
  end

endmodule
`default_nettype wire
